// File: rtl/axis_tuple_bridge.sv
// rtl/axis_tuple_bridge.sv - AXI-Stream to split packet/tuple bridge with an egress tuple queue
// Optional feature macro: AXIS_TUPLE_BRIDGE_DROP_EN (discard packets whose tuple dst_port [31:24] is 0)
// axis_tuple_fifo ports: clk/resetn; push/push_data in; pop in; head/empty/full out; overflow sticky out
// axis_tuple_bridge ports: axis_aclk/axis_resetn; s_axis_* board ingress; pkt_in_*/tuple_in_* to processor;
//   pkt_out_*/tuple_out_* from processor; m_axis_* board egress; err_overflow sticky; drop_count 32-bit

module axis_tuple_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = overflow_q;
    // A pop in the same cycle frees the slot the push lands in, so a full queue still accepts it.
    assign wr_en    = push && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end
endmodule

module axis_tuple_bridge #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_TUPLE_WIDTH      = 128,
    parameter int C_TUPLE_FIFO_DEPTH = 4
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    pkt_in_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  pkt_in_tkeep,
    output logic                            pkt_in_tvalid,
    output logic                            pkt_in_tlast,
    input  logic                            pkt_in_tready,
    output logic                            tuple_in_valid,
    output logic [C_TUPLE_WIDTH-1:0]        tuple_in_data,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    pkt_out_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  pkt_out_tkeep,
    input  logic                            pkt_out_tvalid,
    input  logic                            pkt_out_tlast,
    output logic                            pkt_out_tready,
    input  logic                            tuple_out_valid,
    input  logic [C_TUPLE_WIDTH-1:0]        tuple_out_data,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic                            err_overflow,
    output logic [31:0]                     drop_count
);
    localparam int RW = (C_AXIS_TUSER_WIDTH < C_TUPLE_WIDTH) ? C_AXIS_TUSER_WIDTH : C_TUPLE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SOP,
        ST_BODY
`ifdef AXIS_TUPLE_BRIDGE_DROP_EN
        , ST_DROP
`endif
    } state_t;

    // ---------------- ingress ----------------
    logic in_sop_q, in_sop_d;
    logic in_accept;

    assign pkt_in_tdata  = s_axis_tdata;
    assign pkt_in_tkeep  = s_axis_tkeep;
    assign pkt_in_tlast  = s_axis_tlast;
    assign s_axis_tready = axis_resetn & pkt_in_tready;
    assign pkt_in_tvalid = axis_resetn & s_axis_tvalid;
    assign tuple_in_valid = axis_resetn & s_axis_tvalid & pkt_in_tready & in_sop_q;
    assign in_accept     = s_axis_tvalid & pkt_in_tready;

    always_comb begin
        tuple_in_data         = '0;
        tuple_in_data[RW-1:0] = s_axis_tuser[RW-1:0];
    end

    always_comb begin
        in_sop_d = in_sop_q;
        if (in_accept) begin
            in_sop_d = s_axis_tlast;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            in_sop_q <= 1'b1;
        end else begin
            in_sop_q <= in_sop_d;
        end
    end

    // ---------------- egress ----------------
    state_t                          state_q, state_d;
    logic [C_TUPLE_WIDTH-1:0]        tuple_q, tuple_d;
    logic [C_TUPLE_WIDTH-1:0]        fifo_head;
    logic                            fifo_empty;
    logic                            fifo_full;
    logic                            fifo_pop;
    logic                            out_ready_c;
    logic                            out_valid_c;
    logic [C_AXIS_TUSER_WIDTH-1:0]   tuser_c;
    logic [C_AXIS_TUSER_WIDTH-1:0]   tuple_as_tuser;
    logic                            out_hs;

    axis_tuple_fifo #(
        .WIDTH (C_TUPLE_WIDTH),
        .DEPTH (C_TUPLE_FIFO_DEPTH)
    ) u_tuple_fifo (
        .clk       (axis_aclk),
        .resetn    (axis_resetn),
        .push      (tuple_out_valid),
        .push_data (tuple_out_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .overflow  (err_overflow)
    );

    always_comb begin
        tuple_as_tuser         = '0;
        tuple_as_tuser[RW-1:0] = tuple_q[RW-1:0];
    end

    assign m_axis_tdata   = pkt_out_tdata;
    assign m_axis_tkeep   = pkt_out_tkeep;
    assign m_axis_tlast   = pkt_out_tlast;
    assign m_axis_tuser   = tuser_c;
    assign m_axis_tvalid  = axis_resetn & out_valid_c;
    assign pkt_out_tready = axis_resetn & out_ready_c;
    assign out_hs         = pkt_out_tvalid & m_axis_tready;

`ifdef AXIS_TUPLE_BRIDGE_DROP_EN
    logic [31:0] drop_count_q, drop_count_d;
    assign drop_count = drop_count_q;
`else
    assign drop_count = 32'd0;
`endif

    always_comb begin
        state_d     = state_q;
        tuple_d     = tuple_q;
        fifo_pop    = 1'b0;
        out_ready_c = 1'b0;
        out_valid_c = 1'b0;
        tuser_c     = '0;
`ifdef AXIS_TUPLE_BRIDGE_DROP_EN
        drop_count_d = drop_count_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Waiting for both halves of a packet; the tuple only becomes visible
                // the cycle after it is written, there is no bypass path.
                if (!fifo_empty && pkt_out_tvalid) begin
                    fifo_pop = 1'b1;
                    tuple_d  = fifo_head;
                    state_d  = ST_SOP;
`ifdef AXIS_TUPLE_BRIDGE_DROP_EN
                    if (fifo_head[31:24] == 8'd0) begin
                        state_d = ST_DROP;
                    end
`endif
                end
            end
            ST_SOP: begin
                out_valid_c = pkt_out_tvalid;
                out_ready_c = m_axis_tready;
                tuser_c     = tuple_as_tuser;
                if (out_hs) begin
                    state_d = pkt_out_tlast ? ST_IDLE : ST_BODY;
                end
            end
            ST_BODY: begin
                out_valid_c = pkt_out_tvalid;
                out_ready_c = m_axis_tready;
                if (out_hs && pkt_out_tlast) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef AXIS_TUPLE_BRIDGE_DROP_EN
            ST_DROP: begin
                out_ready_c = 1'b1;
                if (pkt_out_tvalid && pkt_out_tlast) begin
                    if (drop_count_q != 32'hFFFF_FFFF) begin
                        drop_count_d = drop_count_q + 32'd1;
                    end
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state_q <= ST_IDLE;
            tuple_q <= '0;
`ifdef AXIS_TUPLE_BRIDGE_DROP_EN
            drop_count_q <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            tuple_q <= tuple_d;
`ifdef AXIS_TUPLE_BRIDGE_DROP_EN
            drop_count_q <= drop_count_d;
`endif
        end
    end
endmodule

// File: tb/tb_axis_tuple_bridge.sv
// tb/tb_axis_tuple_bridge.sv - randomized self-checking bench for axis_tuple_bridge
module tb_axis_tuple_bridge;
    localparam int DW = 256;
    localparam int KW = DW / 8;
    localparam int UW = 128;
    localparam int TW = 128;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic [UW-1:0] s_tuser = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [DW-1:0] pkt_in_tdata;
    logic [KW-1:0] pkt_in_tkeep;
    logic          pkt_in_tvalid;
    logic          pkt_in_tlast;
    logic          pkt_in_tready = 1'b0;
    logic          tuple_in_valid;
    logic [TW-1:0] tuple_in_data;
    logic [DW-1:0] pkt_out_tdata = '0;
    logic [KW-1:0] pkt_out_tkeep = '0;
    logic          pkt_out_tvalid = 1'b0;
    logic          pkt_out_tlast = 1'b0;
    logic          pkt_out_tready;
    logic          tuple_out_valid = 1'b0;
    logic [TW-1:0] tuple_out_data = '0;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b0;
    logic          err_overflow;
    logic [31:0]   drop_count;

    always #5 clk = ~clk;

    axis_tuple_bridge #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .C_TUPLE_WIDTH      (TW),
        .C_TUPLE_FIFO_DEPTH (DEPTH)
    ) dut (
        .axis_aclk       (clk),
        .axis_resetn     (resetn),
        .s_axis_tdata    (s_tdata),
        .s_axis_tkeep    (s_tkeep),
        .s_axis_tuser    (s_tuser),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tlast    (s_tlast),
        .s_axis_tready   (s_tready),
        .pkt_in_tdata    (pkt_in_tdata),
        .pkt_in_tkeep    (pkt_in_tkeep),
        .pkt_in_tvalid   (pkt_in_tvalid),
        .pkt_in_tlast    (pkt_in_tlast),
        .pkt_in_tready   (pkt_in_tready),
        .tuple_in_valid  (tuple_in_valid),
        .tuple_in_data   (tuple_in_data),
        .pkt_out_tdata   (pkt_out_tdata),
        .pkt_out_tkeep   (pkt_out_tkeep),
        .pkt_out_tvalid  (pkt_out_tvalid),
        .pkt_out_tlast   (pkt_out_tlast),
        .pkt_out_tready  (pkt_out_tready),
        .tuple_out_valid (tuple_out_valid),
        .tuple_out_data  (tuple_out_data),
        .m_axis_tdata    (m_tdata),
        .m_axis_tkeep    (m_tkeep),
        .m_axis_tuser    (m_tuser),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tlast    (m_tlast),
        .m_axis_tready   (m_tready),
        .err_overflow    (err_overflow),
        .drop_count      (drop_count)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
        logic          first;
    } beat_t;

    beat_t         exp_q[$];
    logic [UW-1:0] first_user_log[$];
    int            checks = 0;
    int            passes = 0;
    bit            sb_en = 1'b1;
    bit            silent = 1'b0;
    bit            m_rdy_rand = 1'b0;
    bit            in_rdy_rand = 1'b0;
    int            in_beat_idx = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: got timeout required handshake", name);
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Ingress reference: position of the next beat within the current packet.
    always @(posedge clk) begin
        if (!resetn) in_beat_idx = 0;
        else if (s_tvalid && pkt_in_tready) in_beat_idx = s_tlast ? 0 : in_beat_idx + 1;
    end

    always @(negedge clk) begin
        check("ingress_ctl", {pkt_in_tvalid, s_tready, tuple_in_valid, pkt_in_tlast},
              {resetn && s_tvalid, resetn && pkt_in_tready,
               resetn && s_tvalid && pkt_in_tready && (in_beat_idx == 0), s_tlast});
        check("ingress_data", {pkt_in_tkeep, pkt_in_tdata[DW-KW-1:0]}, {s_tkeep, s_tdata[DW-KW-1:0]});
        check("ingress_tuple", tuple_in_data, TW'(s_tuser));
        if (resetn) begin
            if (silent) check("drop_silent", m_tvalid, 0);
            if (sb_en && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    fail_now("egress_extra_beat");
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("egress_data", m_tdata, e.data);
                    check("egress_keep_last", {m_tkeep, m_tlast}, {e.keep, e.last});
                    check("egress_tuser", m_tuser, e.user);
                    if (e.first) first_user_log.push_back(m_tuser);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (m_rdy_rand) m_tready = ($urandom % 4) != 0;
        if (in_rdy_rand) pkt_in_tready = ($urandom % 3) != 0;
    end

    task automatic push_tuple(input logic [TW-1:0] t);
        tuple_out_valid = 1'b1;
        tuple_out_data  = t;
        @(posedge clk); #1;
        tuple_out_valid = 1'b0;
    endtask

    // mode 0: tuple pushed ahead, 1: tuple with first beat, 2: tuple already queued
    task automatic send_pkt(input logic [TW-1:0] tup, input int nbeats, input int mode);
        beat_t b;
        bit    drop;
        bit    done;
        int    n;
        drop = 1'b0;
`ifdef AXIS_TUPLE_BRIDGE_DROP_EN
        drop = (tup[31:24] == 8'd0);
`endif
        if (mode == 0) begin
            push_tuple(tup);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pkt_out_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            b.data  = rand256();
            b.last  = (i == nbeats - 1);
            b.keep  = b.last ? KW'($urandom) | KW'(1) : '1;
            b.user  = (i == 0) ? UW'(tup) : '0;
            b.first = (i == 0);
            if (!drop) exp_q.push_back(b);
            pkt_out_tdata  = b.data;
            pkt_out_tkeep  = b.keep;
            pkt_out_tlast  = b.last;
            pkt_out_tvalid = 1'b1;
            if (mode == 1 && i == 0) begin
                tuple_out_valid = 1'b1;
                tuple_out_data  = tup;
            end
            done = 1'b0;
            n = 0;
            while (!done) begin
                @(negedge clk);
                if (mode == 1 && i == 0 && n == 0) check("same_cycle_stall", pkt_out_tready, 0);
                done = pkt_out_tready;
                @(posedge clk); #1;
                tuple_out_valid = 1'b0;
                n++;
                if (!done && n > 300) begin
                    fail_now("egress_handshake");
                    done = 1'b1;
                end
            end
        end
        pkt_out_tvalid = 1'b0;
        pkt_out_tlast  = 1'b0;
    endtask

    task automatic send_in(input int nbeats, input logic [UW-1:0] tuser);
        bit done;
        int n;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_tdata  = rand256();
            s_tkeep  = KW'($urandom);
            s_tuser  = (i == 0) ? tuser : UW'(rand256());
            s_tlast  = (i == nbeats - 1);
            s_tvalid = 1'b1;
            done = 1'b0;
            n = 0;
            while (!done) begin
                @(negedge clk);
                done = pkt_in_tready;
                @(posedge clk); #1;
                n++;
                if (!done && n > 300) begin
                    fail_now("ingress_handshake");
                    done = 1'b1;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    localparam logic [TW-1:0] TUP_A = 128'hA0A0_0000_0000_0000_0000_0000_0200_00AA;
    localparam logic [TW-1:0] TUP_B = 128'hB0B0_0000_0000_0000_0000_0000_0300_00BB;
    localparam logic [TW-1:0] TUP_R = 128'h0000_0000_0000_0000_0000_0000_0700_0077;

    initial begin
        logic [TW-1:0] t5 [5];
        logic [2:0]    tv;
        logic [TW-1:0] td;
        for (int k = 0; k < 5; k++) t5[k] = {32'h5000_0000, 64'h0, 8'h04, 16'h0, 8'(k + 1)};

        // reset state with every input asserted
        s_tvalid = 1'b1; pkt_in_tready = 1'b1; pkt_out_tvalid = 1'b1; m_tready = 1'b1;
        tuple_out_valid = 1'b1; tuple_out_data = TUP_A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {s_tready, pkt_in_tvalid, tuple_in_valid, pkt_out_tready, m_tvalid}, 0);
        @(posedge clk); #1;
        s_tvalid = 1'b0; pkt_out_tvalid = 1'b0; tuple_out_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        check("reset_err_drop", {err_overflow, drop_count}, 0);
        check("reset_m_tvalid", m_tvalid, 0);
        @(posedge clk); #1;

        // ingress 3-beat packet, tuple strobe only on the first beat
        tv = '0;
        for (int i = 0; i < 3; i++) begin
            s_tdata = rand256(); s_tkeep = '1; s_tvalid = 1'b1; s_tlast = (i == 2);
            s_tuser = (i == 0) ? UW'(128'h0104_0040) : UW'(128'h9999);
            @(negedge clk);
            tv[i] = tuple_in_valid;
            if (i == 0) td = tuple_in_data;
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        check("ingress_strobe_beats", tv, 3'b001);
        check("ingress_tuple_value", td, 128'h0104_0040);

        // egress ordering: two queued tuples, then two packets
        m_tready = 1'b1;
        first_user_log.delete();
        push_tuple(TUP_A);
        push_tuple(TUP_B);
        send_pkt(TUP_A, 2, 2);
        send_pkt(TUP_B, 3, 2);
        drain();
        check("order_first_A", first_user_log.size() > 0 ? first_user_log[0] : '0, TUP_A);
        check("order_second_B", first_user_log.size() > 1 ? first_user_log[1] : '0, TUP_B);

        // tuple arriving with the first beat
        first_user_log.delete();
        send_pkt(TUP_R, 2, 1);
        drain();
        check("same_cycle_tuser", first_user_log.size() > 0 ? first_user_log[0] : '0, TUP_R);

        // overflow: five tuples into four entries
        for (int k = 0; k < 5; k++) begin
            tuple_out_valid = 1'b1;
            tuple_out_data  = t5[k];
            @(posedge clk); #1;
            if (k == 3) check("no_overflow_at_4", err_overflow, 0);
        end
        tuple_out_valid = 1'b0;
        check("overflow_at_5", err_overflow, 1);
        first_user_log.delete();
        for (int k = 0; k < 4; k++) send_pkt(t5[k], 2, 2);
        drain();
        for (int k = 0; k < 4; k++)
            check("overflow_order", first_user_log.size() > k ? first_user_log[k] : '0, t5[k]);
        check("overflow_sticky", err_overflow, 1);

        // dst_port 0 tuple
`ifdef AXIS_TUPLE_BRIDGE_DROP_EN
        silent = 1'b1;
`endif
        send_pkt(128'h0000_0000_0000_0000_0000_0000_00FF_FFFF, 2, 0);
        repeat (3) @(posedge clk); #1;
        silent = 1'b0;
        drain();
`ifdef AXIS_TUPLE_BRIDGE_DROP_EN
        check("drop_count", drop_count, 1);
`else
        check("drop_count", drop_count, 0);
`endif

        // randomized traffic on both directions
        m_rdy_rand = 1'b1;
        in_rdy_rand = 1'b1;
        fork
            begin
                repeat (40) send_in($urandom_range(1, 4), UW'(rand256()));
            end
            begin
                repeat (30) begin
                    logic [TW-1:0] t;
                    t = TW'(rand256());
                    t[31:24] = t[31:24] | 8'h01;
                    send_pkt(t, $urandom_range(1, 5), $urandom_range(0, 1));
                end
            end
        join
        m_rdy_rand = 1'b0;
        in_rdy_rand = 1'b0;
        m_tready = 1'b1;
        drain();

        // reset cut in the middle of a packet
        sb_en = 1'b0;
        push_tuple(TUP_A);
        pkt_out_tdata = rand256(); pkt_out_tkeep = '1; pkt_out_tlast = 1'b0; pkt_out_tvalid = 1'b1;
        for (int n = 0; n < 20 && !pkt_out_tready; n++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        m_tready = 1'b0;
        pkt_out_tdata = rand256();
        s_tvalid = 1'b1; pkt_in_tready = 1'b1;
        @(posedge clk); #1;
        check("body_held", {m_tvalid, pkt_out_tready}, 2'b10);
        resetn = 1'b0;
        m_tready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midpkt_reset_outputs", {s_tready, pkt_in_tvalid, tuple_in_valid, pkt_out_tready, m_tvalid}, 0);
        check("midpkt_reset_err", err_overflow, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        s_tvalid = 1'b0;
        pkt_out_tvalid = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        first_user_log.delete();
        sb_en = 1'b1;
        send_pkt(TUP_B, 3, 0);
        drain();
        check("post_reset_tuser", first_user_log.size() > 0 ? first_user_log[0] : '0, TUP_B);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
